// File: rtl/top_memoryaccess_pkg.sv
// ----------------------------------------------------------------------------
// top_memoryaccess_pkg
// Shared constants for the RockWave memory-access stage: datapath widths,
// decoded_op bit positions, funct3 codes, FSM state type and the misalignment
// rule used when MEM_MISALIGN_TRAP_EN is defined.
// ----------------------------------------------------------------------------
package top_memoryaccess_pkg;

    localparam int XLEN  = 32;
    localparam int OPLEN = 10;

    // decoded_op field positions
    localparam int MEM_LOAD_BIT  = 0;
    localparam int MEM_STORE_BIT = 1;
    localparam int MUST_JUMP_BIT = 2;
    localparam int FUNCT3_BIT_L  = 3;
    localparam int FUNCT3_BIT_M  = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } ma_state_t;

    // Halfword accesses need an even offset, word accesses a zero offset.
    // Loads and stores share funct3 codes for H/W, and HU is a load only.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/top_memoryaccess_if.sv
// ----------------------------------------------------------------------------
// top_memoryaccess_if
// Data-memory req/ack bus.
//   dmem_req   master->slave  request, held until dmem_ack
//   dmem_we    master->slave  1 = write
//   dmem_addr  master->slave  word-aligned address
//   dmem_wdata master->slave  lane-replicated store data
//   dmem_be    master->slave  byte enables
//   dmem_rdata slave->master  read data, valid with dmem_ack
//   dmem_ack   slave->master  transfer complete
// ----------------------------------------------------------------------------
interface top_memoryaccess_if;
    import top_memoryaccess_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/top_memoryaccess_mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane handling for the memory-access stage.
//   funct3     in   access size / signedness
//   off        in   byte offset within the word (address bits [1:0])
//   store_data in   rs2 value to be stored
//   load_raw   in   word returned by the data bus
//   wdata      out  store data replicated across lanes
//   be         out  store byte enables (0 for unsupported funct3)
//   load_data  out  shifted and sign/zero-extended load result
// ----------------------------------------------------------------------------
module mem_lane_align
    import top_memoryaccess_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_raw,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] load_data
);

    // Only the low halfword of the shifted word is ever consumed.
    logic [15:0] load_sh;

    assign load_sh = 16'(load_raw >> {off, 3'b000});

    always_comb begin
        wdata = store_data;
        be    = 4'b0000;
        case (funct3)
            F3_B: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << off;
            end
            F3_H: begin
                wdata = {2{store_data[15:0]}};
                // offset 3 drops the upper lane rather than wrapping
                be    = 4'b0011 << off;
            end
            F3_W: begin
                wdata = store_data;
                be    = 4'b1111;
            end
            default: begin
                wdata = store_data;
                be    = 4'b0000;
            end
        endcase
    end

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){load_sh[7]}}, load_sh[7:0]};
            F3_H:    load_data = {{(XLEN-16){load_sh[15]}}, load_sh[15:0]};
            F3_W:    load_data = load_raw;
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, load_sh[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, load_sh[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/top_memoryaccess.sv
// ----------------------------------------------------------------------------
// top_memoryaccess
// Memory-access stage of the RockWave multi-cycle core. Issues loads/stores on
// the req/ack data bus during phase_memoryaccess, stalls the phase machine
// until the bus acknowledges, and registers writeback data and next PC.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   phase_memoryaccess    memory-access phase from the state machine
//   decoded_op_em         load/store/must-jump bits and funct3
//   jump_state_em         next PC is the jump target (alu_out_em)
//   rdsel_em              destination register
//   next_pc_em            sequential PC
//   alu_out_em            effective address or jump target
//   rs2data_em            store data
//   dmem                  data-memory bus (master modport)
//   stall_memoryaccess    combinational hold for the phase machine
//   rdsel_mw, rddata_mw   registered writeback register/data
//   next_pc_mw            registered resolved next PC
//   misalign_mw           misaligned-access flag (only with MEM_MISALIGN_TRAP_EN)
//
// Build option: define MEM_MISALIGN_TRAP_EN to suppress the bus cycle for
// misaligned halfword/word accesses and report them on misalign_mw.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no bus cycle; starts one when the phase carries a memory op
// ST_REQ  | request on the bus, waiting for dmem_ack
// ----------------------------------------------------------------------------
module top_memoryaccess
    import top_memoryaccess_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                phase_memoryaccess,
    input  logic [OPLEN-1:0]    decoded_op_em,
    input  logic                jump_state_em,
    input  logic [4:0]          rdsel_em,
    input  logic [XLEN-1:0]     next_pc_em,
    input  logic [XLEN-1:0]     alu_out_em,
    input  logic [XLEN-1:0]     rs2data_em,
    top_memoryaccess_if.master  dmem,
    output logic                stall_memoryaccess,
    output logic [4:0]          rdsel_mw,
    output logic [XLEN-1:0]     rddata_mw,
    output logic [XLEN-1:0]     next_pc_mw
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                misalign_mw
`endif
);

    logic            is_load;
    logic            is_store;
    logic            must_jump;
    logic [2:0]      funct3;
    logic [1:0]      off;
    logic            mem_op;
    logic            misaligned;
    logic            bus_op;
    logic            capture;

    logic [XLEN-1:0] lane_wdata;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] rddata_next;
    logic [XLEN-1:0] next_pc_next;

    ma_state_t       state;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;

    logic            unused_op_bits;

    assign is_load   = decoded_op_em[MEM_LOAD_BIT];
    assign is_store  = decoded_op_em[MEM_STORE_BIT];
    assign must_jump = decoded_op_em[MUST_JUMP_BIT];
    assign funct3    = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
    assign off       = alu_out_em[1:0];
    assign mem_op    = is_load | is_store;

    assign unused_op_bits = ^decoded_op_em[OPLEN-1:FUNCT3_BIT_M+1];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = mem_op & is_misaligned(funct3, off);
`else
    assign misaligned = 1'b0;
`endif

    assign bus_op = mem_op & ~misaligned;

    mem_lane_align u_lane (
        .funct3     (funct3),
        .off        (off),
        .store_data (rs2data_em),
        .load_raw   (dmem.dmem_rdata),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .load_data  (load_data)
    );

    // Stall is forced low while reset is held so the phase machine is
    // released at the same instant the bus request is dropped.
    always_comb begin
        stall_memoryaccess = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: stall_memoryaccess = phase_memoryaccess & bus_op;
                ST_REQ:  stall_memoryaccess = ~dmem.dmem_ack;
                default: stall_memoryaccess = 1'b0;
            endcase
        end
    end

    assign capture = phase_memoryaccess & ~stall_memoryaccess;

    // Store wins when both memory bits are set; stores write back the address.
    always_comb begin
        rddata_next = alu_out_em;
        if (misaligned || is_store) begin
            rddata_next = alu_out_em;
        end else if (is_load) begin
            rddata_next = load_data;
        end else if (must_jump) begin
            rddata_next = next_pc_em;
        end
    end

    assign next_pc_next = jump_state_em ? {alu_out_em[XLEN-1:1], 1'b0} : next_pc_em;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (phase_memoryaccess && bus_op) begin
                        state   <= ST_REQ;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {alu_out_em[XLEN-1:2], 2'b00};
                        wdata_q <= is_store ? lane_wdata : '0;
                        // loads read the whole word; lanes are picked on return
                        be_q    <= is_store ? lane_be : 4'b1111;
                    end
                end
                ST_REQ: begin
                    if (dmem.dmem_ack) begin
                        state   <= ST_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        be_q    <= 4'b0000;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdsel_mw    <= 5'd0;
            rddata_mw   <= '0;
            next_pc_mw  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_mw <= 1'b0;
`endif
        end else if (capture) begin
            rdsel_mw    <= rdsel_em;
            rddata_mw   <= rddata_next;
            next_pc_mw  <= next_pc_next;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_mw <= misaligned;
`endif
        end
    end

endmodule
